// File: rtl/tile_scheduler_pkg.sv
// Shared types and geometry helpers for the tile scheduler.
//   sched_state_t        : scheduler FSM state encoding
//   tiles_per_row/col    : tile grid dimensions for a given screen and tile size
//   tile_count           : total tiles per frame
//   buf_idx_w / cnt_w    : widths of a buffer index and of a 0..NUM_BUFS count
package typhoon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } sched_state_t;

    function automatic int tiles_per_row(input int screen_w, input int tile_dim);
        return screen_w / tile_dim;
    endfunction

    function automatic int tiles_per_col(input int screen_h, input int tile_dim);
        return screen_h / tile_dim;
    endfunction

    function automatic int tile_count(input int screen_w, input int screen_h, input int tile_dim);
        return tiles_per_row(screen_w, tile_dim) * tiles_per_col(screen_h, tile_dim);
    endfunction

    function automatic int buf_idx_w(input int num_bufs);
        return (num_bufs > 1) ? $clog2(num_bufs) : 1;
    endfunction

    function automatic int cnt_w(input int num_bufs);
        return $clog2(num_bufs + 1);
    endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its environment
// (frame control, tile rasterizer, framebuffer streamer).
//   frame_go, continuous          : frame control from the host
//   raster_start/x/y/buf, raster_done : rasterizer request / completion
//   stream_start/x/y/buf, stream_done : streamer request / completion
//   frame_sel, frame_done, busy, err  : status back to the host
// master = scheduler side, slave = environment side.
interface tile_scheduler_if #(
    parameter int COORD_W = 10,
    parameter int BUF_W   = 1
);
    logic               frame_go;
    logic               continuous;

    logic               raster_start;
    logic [COORD_W-1:0] raster_x;
    logic [COORD_W-1:0] raster_y;
    logic [BUF_W-1:0]   raster_buf;
    logic               raster_done;

    logic               stream_start;
    logic [COORD_W-1:0] stream_x;
    logic [COORD_W-1:0] stream_y;
    logic [BUF_W-1:0]   stream_buf;
    logic               stream_done;

    logic               frame_sel;
    logic               frame_done;
    logic               busy;
    logic               err;

    modport master (
        input  frame_go, continuous, raster_done, stream_done,
        output raster_start, raster_x, raster_y, raster_buf,
               stream_start, stream_x, stream_y, stream_buf,
               frame_sel, frame_done, busy, err
    );

    modport slave (
        output frame_go, continuous, raster_done, stream_done,
        input  raster_start, raster_x, raster_y, raster_buf,
               stream_start, stream_x, stream_y, stream_buf,
               frame_sel, frame_done, busy, err
    );
endinterface

// File: rtl/tile_scheduler_buf_ring.sv
// Ring of NUM_BUFS on-chip tile buffers used in strict rotation.
//   clk, rst_n        : clock, async active-low reset
//   alloc, wr_x, wr_y : claim the buffer at alloc_ptr and record its tile origin
//   fill              : a rasterized buffer became ready for streaming
//   free              : the buffer at rd_ptr has been streamed out
//   alloc_ptr, rd_ptr : next buffer to allocate / next buffer to stream
//   rd_x, rd_y        : stored tile origin of the buffer at rd_ptr
//   full              : every buffer is allocated
//   filled            : at least one buffer is waiting to be streamed
//   one_left          : exactly one buffer is still allocated
module tile_buf_ring
    import typhoon_pkg::*;
#(
    parameter int NUM_BUFS = 2,
    parameter int COORD_W  = 10,
    parameter int BUF_W    = buf_idx_w(NUM_BUFS),
    parameter int CNT_W    = cnt_w(NUM_BUFS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               fill,
    input  logic               free,
    output logic [BUF_W-1:0]   alloc_ptr,
    output logic [BUF_W-1:0]   rd_ptr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               full,
    output logic               filled,
    output logic               one_left
);

    logic [CNT_W-1:0]   alloc_cnt;
    logic [CNT_W-1:0]   fill_cnt;
    logic [COORD_W-1:0] x_mem [NUM_BUFS];
    logic [COORD_W-1:0] y_mem [NUM_BUFS];

    function automatic logic [BUF_W-1:0] next_ptr(input logic [BUF_W-1:0] p);
        return (p == BUF_W'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
            fill_cnt  <= '0;
            for (int i = 0; i < NUM_BUFS; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
        end else begin
            if (alloc) begin
                x_mem[alloc_ptr] <= wr_x;
                y_mem[alloc_ptr] <= wr_y;
                alloc_ptr        <= next_ptr(alloc_ptr);
            end
            if (free) begin
                rd_ptr <= next_ptr(rd_ptr);
            end

            // alloc and free on the same edge cancel in the allocation count
            unique case ({alloc, free})
                2'b10:   alloc_cnt <= alloc_cnt + 1'b1;
                2'b01:   alloc_cnt <= alloc_cnt - 1'b1;
                default: alloc_cnt <= alloc_cnt;
            endcase

            // likewise a fill and a free together leave fill_cnt unchanged
            unique case ({fill, free})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    assign rd_x     = x_mem[rd_ptr];
    assign rd_y     = y_mem[rd_ptr];
    assign full     = (alloc_cnt == CNT_W'(NUM_BUFS));
    assign filled   = (fill_cnt != '0);
    assign one_left = (alloc_cnt == CNT_W'(1));

endmodule

// File: rtl/tile_scheduler.sv
// Tile sequencer between the tile rasterizer and the framebuffer streamer.
// Walks the screen in raster tile order, hands each tile to the rasterizer
// in a free tile buffer, streams filled buffers out in the same order and
// swaps front/back framebuffers at frame end.
//   BOARD_CLK : system clock
//   RESET_N   : asynchronous active-low reset
//   bus       : tile_scheduler_if master (frame control, raster and stream
//               handshakes, status)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for frame_go
//   RUN   | issuing tiles to the rasterizer, streaming filled buffers
//   DRAIN | all tiles issued, waiting for the last stream_done
//   SWAP  | one cycle: toggle frame_sel, pulse frame_done
module tile_scheduler
    import typhoon_pkg::*;
#(
    parameter int TILE_DIM = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int NUM_BUFS = 2,
    parameter int COORD_W  = 10
) (
    input  logic             BOARD_CLK,
    input  logic             RESET_N,
    tile_scheduler_if.master bus
);

    localparam int BUF_W = buf_idx_w(NUM_BUFS);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(TILE_DIM);
    localparam logic [COORD_W-1:0] LAST_X =
        COORD_W'((tiles_per_row(SCREEN_W, TILE_DIM) - 1) * TILE_DIM);
    localparam logic [COORD_W-1:0] LAST_Y =
        COORD_W'((tiles_per_col(SCREEN_H, TILE_DIM) - 1) * TILE_DIM);

    generate
        if ((SCREEN_W % TILE_DIM) != 0) begin : g_bad_width
            $error("SCREEN_W must be a multiple of TILE_DIM");
        end
        if ((SCREEN_H % TILE_DIM) != 0) begin : g_bad_height
            $error("SCREEN_H must be a multiple of TILE_DIM");
        end
        if ((NUM_BUFS < 2) || (NUM_BUFS > 8)) begin : g_bad_bufs
            $error("NUM_BUFS must be in 2..8");
        end
        if (((SCREEN_W - 1) >= (1 << COORD_W)) || ((SCREEN_H - 1) >= (1 << COORD_W))) begin : g_bad_coord
            $error("COORD_W too narrow for the screen");
        end
        if (tile_count(SCREEN_W, SCREEN_H, TILE_DIM) < 1) begin : g_no_tiles
            $error("screen holds no tiles");
        end
    endgenerate

    sched_state_t state, state_nxt;

    logic [COORD_W-1:0] cur_x, cur_y;
    logic               all_issued;
    logic               raster_busy, stream_busy;

    logic               raster_start_q, stream_start_q;
    logic [COORD_W-1:0] raster_x_q, raster_y_q, stream_x_q, stream_y_q;
    logic [BUF_W-1:0]   raster_buf_q, stream_buf_q;
    logic               frame_sel_q, frame_done_q, err_q;

    logic [BUF_W-1:0]   alloc_ptr, rd_ptr;
    logic [COORD_W-1:0] rd_x, rd_y;
    logic               full, filled, one_left;

    logic raster_ack, stream_ack;
    logic raster_issue, stream_issue;
    logic last_tile;

    // done pulses only count when the matching operation is in flight
    assign raster_ack   = bus.raster_done & raster_busy;
    assign stream_ack   = bus.stream_done & stream_busy;
    assign raster_issue = (state == RUN) & ~raster_busy & ~all_issued & ~full;
    assign stream_issue = filled & ~stream_busy;
    assign last_tile    = (cur_x == LAST_X) && (cur_y == LAST_Y);

    tile_buf_ring #(
        .NUM_BUFS (NUM_BUFS),
        .COORD_W  (COORD_W)
    ) u_ring (
        .clk       (BOARD_CLK),
        .rst_n     (RESET_N),
        .alloc     (raster_issue),
        .wr_x      (cur_x),
        .wr_y      (cur_y),
        .fill      (raster_ack),
        .free      (stream_ack),
        .alloc_ptr (alloc_ptr),
        .rd_ptr    (rd_ptr),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .full      (full),
        .filled    (filled),
        .one_left  (one_left)
    );

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.frame_go) state_nxt = RUN;
            RUN:     if (all_issued) state_nxt = DRAIN;
            // the buffer being freed is the only one left: it was the last tile
            DRAIN:   if (stream_ack && one_left) state_nxt = SWAP;
            SWAP:    state_nxt = bus.continuous ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cur_x          <= '0;
            cur_y          <= '0;
            all_issued     <= 1'b0;
            raster_busy    <= 1'b0;
            stream_busy    <= 1'b0;
            raster_start_q <= 1'b0;
            raster_x_q     <= '0;
            raster_y_q     <= '0;
            raster_buf_q   <= '0;
            stream_start_q <= 1'b0;
            stream_x_q     <= '0;
            stream_y_q     <= '0;
            stream_buf_q   <= '0;
            frame_sel_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            raster_start_q <= raster_issue;
            stream_start_q <= stream_issue;
            frame_done_q   <= (state_nxt == SWAP);
            if (state_nxt == SWAP) begin
                frame_sel_q <= ~frame_sel_q;
            end

            // the walk restarts from (0,0) whenever a new frame can begin
            if ((state == IDLE) || (state == SWAP)) begin
                cur_x      <= '0;
                cur_y      <= '0;
                all_issued <= 1'b0;
            end else if (raster_issue) begin
                if (last_tile) begin
                    all_issued <= 1'b1;
                end else if (cur_x == LAST_X) begin
                    cur_x <= '0;
                    cur_y <= cur_y + STEP;
                end else begin
                    cur_x <= cur_x + STEP;
                end
            end

            if (raster_issue) begin
                raster_x_q   <= cur_x;
                raster_y_q   <= cur_y;
                raster_buf_q <= alloc_ptr;
                raster_busy  <= 1'b1;
            end else if (raster_ack) begin
                raster_busy <= 1'b0;
            end

            if (stream_issue) begin
                stream_x_q   <= rd_x;
                stream_y_q   <= rd_y;
                stream_buf_q <= rd_ptr;
                stream_busy  <= 1'b1;
            end else if (stream_ack) begin
                stream_busy <= 1'b0;
            end

            if ((bus.raster_done && !raster_busy) || (bus.stream_done && !stream_busy)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.raster_start = raster_start_q;
    assign bus.raster_x     = raster_x_q;
    assign bus.raster_y     = raster_y_q;
    assign bus.raster_buf   = raster_buf_q;
    assign bus.stream_start = stream_start_q;
    assign bus.stream_x     = stream_x_q;
    assign bus.stream_y     = stream_y_q;
    assign bus.stream_buf   = stream_buf_q;
    assign bus.frame_sel    = frame_sel_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (state != IDLE);
    assign bus.err          = err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler on a 32x16 screen with 8-pixel tiles.
// One instance uses two buffers, a second uses four buffers with its
// rasterizer/streamer responder releasing done pulses together.
module tb_tile_scheduler;

    localparam int W  = 32;
    localparam int H  = 16;
    localparam int T  = 8;
    localparam int CW = 10;
    localparam int NT = (W / T) * (H / T);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_scheduler_if #(.COORD_W(CW), .BUF_W(1)) bus2 ();
    tile_scheduler_if #(.COORD_W(CW), .BUF_W(2)) bus4 ();

    tile_scheduler #(
        .TILE_DIM(T), .SCREEN_W(W), .SCREEN_H(H), .NUM_BUFS(2), .COORD_W(CW)
    ) u_dut2 (
        .BOARD_CLK (clk),
        .RESET_N   (rst_n),
        .bus       (bus2.master)
    );

    tile_scheduler #(
        .TILE_DIM(T), .SCREEN_W(W), .SCREEN_H(H), .NUM_BUFS(4), .COORD_W(CW)
    ) u_dut4 (
        .BOARD_CLK (clk),
        .RESET_N   (rst_n),
        .bus       (bus4.master)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] tile_word(input int b, input int x, input int y);
        return {8'(b), 12'(y), 12'(x)};
    endfunction

    // expected-result queues
    logic [31:0] rq2[$], sq2[$], fq2[$];
    logic [31:0] rq4[$], sq4[$], fq4[$];
    int   buf2 = 0, buf4 = 0;
    logic sel2 = 1'b0, sel4 = 1'b0;

    task automatic push_frame2();
        for (int ty = 0; ty < H / T; ty++) begin
            for (int tx = 0; tx < W / T; tx++) begin
                rq2.push_back(tile_word(buf2, tx * T, ty * T));
                sq2.push_back(tile_word(buf2, tx * T, ty * T));
                buf2 = (buf2 + 1) % 2;
            end
        end
        sel2 = ~sel2;
        fq2.push_back(32'(sel2));
    endtask

    task automatic push_frame4();
        for (int ty = 0; ty < H / T; ty++) begin
            for (int tx = 0; tx < W / T; tx++) begin
                rq4.push_back(tile_word(buf4, tx * T, ty * T));
                sq4.push_back(tile_word(buf4, tx * T, ty * T));
                buf4 = (buf4 + 1) % 4;
            end
        end
        sel4 = ~sel4;
        fq4.push_back(32'(sel4));
    endtask

    // responder for the two-buffer instance: fixed latencies plus an
    // on-request unsolicited raster_done
    int r_lat2 = 3, s_lat2 = 3;
    int rc2 = 0, sc2 = 0;
    int inj_req2 = 0, inj_ack2 = 0;

    always @(posedge clk) begin
        #1;
        bus2.raster_done = 1'b0;
        bus2.stream_done = 1'b0;
        if (!rst_n) begin
            rc2 = 0;
            sc2 = 0;
        end else begin
            if (rc2 > 0) begin
                rc2--;
                if (rc2 == 0) bus2.raster_done = 1'b1;
            end
            if (sc2 > 0) begin
                sc2--;
                if (sc2 == 0) bus2.stream_done = 1'b1;
            end
            if (bus2.raster_start) rc2 = r_lat2;
            if (bus2.stream_start) sc2 = s_lat2;
            if (inj_req2 != inj_ack2) begin
                bus2.raster_done = 1'b1;
                inj_ack2 = inj_req2;
            end
        end
    end

    // responder for the four-buffer instance: completions are released only
    // every fourth cycle, so raster_done and stream_done tend to coincide
    logic r_pend4 = 1'b0, s_pend4 = 1'b0;
    int   r_age4 = 0, s_age4 = 0, cyc4 = 0;

    always @(posedge clk) begin
        #1;
        bus4.raster_done = 1'b0;
        bus4.stream_done = 1'b0;
        cyc4++;
        if (!rst_n) begin
            r_pend4 = 1'b0;
            s_pend4 = 1'b0;
        end else begin
            if (r_pend4 && r_age4 > 0) r_age4--;
            if (s_pend4 && s_age4 > 0) s_age4--;
            if ((cyc4 % 4) == 0) begin
                if (r_pend4 && r_age4 == 0) begin
                    bus4.raster_done = 1'b1;
                    r_pend4 = 1'b0;
                end
                if (s_pend4 && s_age4 == 0) begin
                    bus4.stream_done = 1'b1;
                    s_pend4 = 1'b0;
                end
            end
            if (bus4.raster_start) begin
                r_pend4 = 1'b1;
                r_age4  = 2;
            end
            if (bus4.stream_start) begin
                s_pend4 = 1'b1;
                s_age4  = 2;
            end
        end
    end

    // monitors: pop and compare on every DUT output event
    int rs2 = 0, sd2 = 0, fd2 = 0, first_gap2 = 0;
    int rs4 = 0, sd4 = 0, fd4 = 0, coin4 = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            rs2 = 0;
            sd2 = 0;
            fd2 = 0;
        end else begin
            if (bus2.raster_start) begin
                check_eq("rs2_room", 32'((rs2 - sd2) < 2), 32'd1);
                check_eq("rs2_expected", 32'(rq2.size() > 0), 32'd1);
                if (rq2.size() > 0) begin
                    e = rq2.pop_front();
                    check_eq("rs2_tile", tile_word(int'(bus2.raster_buf), int'(bus2.raster_x), int'(bus2.raster_y)), e);
                end
                rs2++;
            end
            if (bus2.stream_start) begin
                check_eq("ss2_expected", 32'(sq2.size() > 0), 32'd1);
                if (sq2.size() > 0) begin
                    e = sq2.pop_front();
                    check_eq("ss2_tile", tile_word(int'(bus2.stream_buf), int'(bus2.stream_x), int'(bus2.stream_y)), e);
                end
            end
            if (bus2.stream_done) begin
                if ((sd2 % NT) == 0) first_gap2 = rs2 - sd2;
                sd2++;
            end
            if (bus2.frame_done) begin
                check_eq("fd2_expected", 32'(fq2.size() > 0), 32'd1);
                if (fq2.size() > 0) begin
                    e = fq2.pop_front();
                    check_eq("fd2_frame_sel", 32'(bus2.frame_sel), e);
                end
                fd2++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            rs4 = 0;
            sd4 = 0;
            fd4 = 0;
            coin4 = 0;
        end else begin
            if (bus4.raster_start) begin
                check_eq("rs4_room", 32'((rs4 - sd4) < 4), 32'd1);
                check_eq("rs4_expected", 32'(rq4.size() > 0), 32'd1);
                if (rq4.size() > 0) begin
                    e = rq4.pop_front();
                    check_eq("rs4_tile", tile_word(int'(bus4.raster_buf), int'(bus4.raster_x), int'(bus4.raster_y)), e);
                end
                rs4++;
            end
            if (bus4.stream_start) begin
                check_eq("ss4_expected", 32'(sq4.size() > 0), 32'd1);
                if (sq4.size() > 0) begin
                    e = sq4.pop_front();
                    check_eq("ss4_tile", tile_word(int'(bus4.stream_buf), int'(bus4.stream_x), int'(bus4.stream_y)), e);
                end
            end
            if (bus4.raster_done && bus4.stream_done) coin4++;
            if (bus4.stream_done) sd4++;
            if (bus4.frame_done) begin
                check_eq("fd4_expected", 32'(fq4.size() > 0), 32'd1);
                if (fq4.size() > 0) begin
                    e = fq4.pop_front();
                    check_eq("fd4_frame_sel", 32'(bus4.frame_sel), e);
                end
                fd4++;
            end
        end
    end

    function automatic logic [31:0] ctl2();
        return {26'd0, bus2.raster_start, bus2.stream_start, bus2.frame_sel,
                bus2.frame_done, bus2.busy, bus2.err};
    endfunction

    function automatic logic [31:0] crd2();
        return 32'(|{bus2.raster_x, bus2.raster_y, bus2.raster_buf,
                     bus2.stream_x, bus2.stream_y, bus2.stream_buf});
    endfunction

    function automatic logic [31:0] ctl4();
        return {26'd0, bus4.raster_start, bus4.stream_start, bus4.frame_sel,
                bus4.frame_done, bus4.busy, bus4.err};
    endfunction

    task automatic pulse_go2();
        @(negedge clk) bus2.frame_go = 1'b1;
        @(negedge clk) bus2.frame_go = 1'b0;
    endtask

    task automatic pulse_go4();
        @(negedge clk) bus4.frame_go = 1'b1;
        @(negedge clk) bus4.frame_go = 1'b0;
    endtask

    task automatic wait_fd2(input int target, input int budget);
        int k = 0;
        while (fd2 < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("fd2_wait", 32'(fd2 >= target), 32'd1);
    endtask

    task automatic wait_fd4(input int target, input int budget);
        int k = 0;
        while (fd4 < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("fd4_wait", 32'(fd4 >= target), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus2.frame_go   = 1'b0;
        bus2.continuous = 1'b0;
        bus4.frame_go   = 1'b0;
        bus4.continuous = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl2", ctl2(), 32'd0);
        check_eq("rst_crd2", crd2(), 32'd0);
        check_eq("rst_ctl4", ctl4(), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, 3-cycle latencies
        push_frame2();
        pulse_go2();
        wait_fd2(1, 1000);
        repeat (4) @(negedge clk);
        check_eq("t1_busy", 32'(bus2.busy), 32'd0);
        check_eq("t1_frame_sel", 32'(bus2.frame_sel), 32'd1);
        check_eq("t1_left", 32'(rq2.size() + sq2.size() + fq2.size()), 32'd0);
        check_eq("t1_frames", 32'(fd2), 32'd1);
        check_eq("t1_tiles", 32'(rs2), 32'(NT));

        // streamer stalls 50 cycles per tile
        s_lat2 = 50;
        push_frame2();
        pulse_go2();
        wait_fd2(2, 3000);
        repeat (4) @(negedge clk);
        check_eq("t2_first_gap", 32'(first_gap2), 32'd2);
        check_eq("t2_frame_sel", 32'(bus2.frame_sel), 32'd0);
        check_eq("t2_busy", 32'(bus2.busy), 32'd0);
        s_lat2 = 3;

        // continuous for three frames, with a stray frame_go mid-run
        base = fd2;
        push_frame2();
        push_frame2();
        push_frame2();
        bus2.continuous = 1'b1;
        pulse_go2();
        wait_fd2(base + 1, 1000);
        repeat (4) @(negedge clk);
        check_eq("t3_busy_run", 32'(bus2.busy), 32'd1);
        pulse_go2();
        wait_fd2(base + 2, 1000);
        repeat (3) @(negedge clk);
        bus2.continuous = 1'b0;
        wait_fd2(base + 3, 1000);
        repeat (6) @(negedge clk);
        check_eq("t3_busy", 32'(bus2.busy), 32'd0);
        check_eq("t3_frames", 32'(fd2), 32'(base + 3));
        check_eq("t3_tiles", 32'(rs2), 32'(5 * NT));
        check_eq("t3_left", 32'(rq2.size() + sq2.size() + fq2.size()), 32'd0);
        check_eq("t3_err", 32'(bus2.err), 32'd0);

        // unsolicited raster_done in IDLE
        inj_req2++;
        repeat (3) @(negedge clk);
        check_eq("t4_ctl", ctl2(), {26'd0, 1'b0, 1'b0, sel2, 1'b0, 1'b0, 1'b1});

        // reset in the middle of a frame
        base = rs2;
        push_frame2();
        pulse_go2();
        begin
            int k = 0;
            while (rs2 < base + 3 && k < 500) begin
                @(negedge clk);
                k++;
            end
            check_eq("t5_wait", 32'(rs2 >= base + 3), 32'd1);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_ctl", ctl2(), 32'd0);
        check_eq("t5_async_crd", crd2(), 32'd0);
        rq2.delete();
        sq2.delete();
        fq2.delete();
        buf2 = 0;
        sel2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_frame2();
        pulse_go2();
        wait_fd2(1, 1000);
        repeat (4) @(negedge clk);
        check_eq("t5_ctl", ctl2(), {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check_eq("t5_left", 32'(rq2.size() + sq2.size() + fq2.size()), 32'd0);

        // four buffers with coincident completions
        push_frame4();
        pulse_go4();
        wait_fd4(1, 2000);
        repeat (6) @(negedge clk);
        check_eq("t6_ctl", ctl4(), {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check_eq("t6_left", 32'(rq4.size() + sq4.size() + fq4.size()), 32'd0);
        check_eq("t6_streams", 32'(sd4), 32'(NT));
        check_eq("t6_coincident", 32'(coin4 > 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Parametrised tile sequencer between the tile rasterizer and the framebuffer streamer. It walks the screen in tile order and hands each tile to the rasterizer in a free on-chip tile buffer. Filled buffers go to the streamer in the same order, and front/back framebuffers swap at frame end. It generalises fixed ping-pong sequencing to NUM_BUFS buffers, with real done handshakes, single-frame or continuous mode, and error flagging.

Parameters:
TILE_DIM, 8, tile edge in pixels
SCREEN_W, 640, screen width in pixels; must be a multiple of TILE_DIM (elaboration assertion)
SCREEN_H, 480, screen height in pixels; must be a multiple of TILE_DIM (elaboration assertion)
NUM_BUFS, 2, tile buffers in rotation, 2..8
COORD_W, 10, coordinate width; must hold SCREEN_W-1 and SCREEN_H-1

Ports:
BOARD_CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
frame_go  in  1  pulse: start a frame (honoured in IDLE only)
continuous  in  1  1 = start next frame automatically after swap
raster_start  out  1  one-cycle pulse: rasterize tile
raster_x, raster_y  out  COORD_W  tile origin for raster_start
raster_buf  out  $clog2(NUM_BUFS)  target buffer for raster_start
raster_done  in  1  one-cycle pulse: in-flight raster complete
stream_start  out  1  one-cycle pulse: write buffer to SRAM
stream_x, stream_y  out  COORD_W  tile origin for stream_start
stream_buf  out  $clog2(NUM_BUFS)  source buffer
stream_done  in  1  one-cycle pulse: in-flight stream complete
frame_sel  out  1  framebuffer being written; toggles at swap
frame_done  out  1  one-cycle pulse at swap
busy  out  1  state != IDLE
err  out  1  sticky: unsolicited raster_done or stream_done

Behaviour:
- Reset values: all outputs 0; state IDLE; pointers, counts, coordinates 0. Reset mid-frame abandons in-flight work; later done pulses from that work set err.
- States: IDLE -> RUN on frame_go. RUN -> DRAIN the cycle after the last tile's raster_start. DRAIN -> SWAP when the last stream_done arrives. SWAP (1 cycle) -> RUN if continuous, else IDLE.
- SWAP: frame_sel toggles, frame_done pulses, tile coordinates reset to (0,0). Entering RUN from IDLE also resets coordinates.
- Buffer ring: alloc_ptr, rd_ptr, alloc_cnt (0..NUM_BUFS), fill_cnt. Buffers are used in strict rotation 0..NUM_BUFS-1; coordinates are stored per buffer.
- Raster issue: allowed in RUN when no raster is in flight, tiles remain, and alloc_cnt < NUM_BUFS. Registered outputs: raster_start pulses one cycle after the condition is seen at a clock edge, with raster_buf = alloc_ptr. alloc_cnt increments on the same edge.
- Raster order: x += TILE_DIM. At x == SCREEN_W-TILE_DIM, x wraps to 0 and y += TILE_DIM. The last tile is (SCREEN_W-TILE_DIM, SCREEN_H-TILE_DIM).
- raster_done: fill_cnt increments and the raster-in-flight flag clears. The next raster_start can occur at the earliest 1 cycle after raster_done.
- Stream issue: allowed when fill_cnt > 0 and no stream is in flight. stream_start pulses with rd_ptr's stored coordinates.
- stream_done: rd_ptr advances, and fill_cnt and alloc_cnt decrement. This frees the buffer.
- Simultaneous raster_done and stream_done in the same cycle: both are applied; net fill_cnt is unchanged.
- A raster_done or stream_done with no matching operation in flight is ignored and sets err. err clears only on reset.
- frame_go outside IDLE is ignored. Dropping continuous mid-frame takes effect at the next SWAP.
- Arithmetic: coordinates are unsigned COORD_W; there are no subtractive edge tests and no underflow.

Decomposition:
- Package typhoon_pkg: sched_state_t enum (IDLE, RUN, DRAIN, SWAP); the tiles-per-row, tiles-per-column and tile-count functions of the parameters.
- Sub-module tile_buf_ring: pointers, counts, and the per-buffer coordinate store. Its interface is alloc, fill, free, coordinate write and coordinate read.

Test Plan:
- Params W=32, H=16, TILE=8, NUM_BUFS=2; frame_go; rasterizer and streamer answer done 3 cycles after start -> 8 raster_starts at (0,0),(8,0),(16,0),(24,0),(0,8)..(24,8), buffers 0,1,0,1...; streams in identical order; one frame_done; frame_sel=1; busy=0.
- Streamer stalls 50 cycles per tile -> at most 2 raster_starts before the first stream_done; raster_start never issued with alloc_cnt=2.
- NUM_BUFS=4 with raster_done and stream_done forced coincident -> counts consistent; all 8 tiles streamed exactly once.
- continuous=1 for 3 frames -> 3 frame_done pulses; frame_sel sequence 1,0,1; coordinates restart at (0,0) each frame.
- raster_done pulsed in IDLE -> err=1, no other output change; RESET_N low mid-frame -> all outputs 0 asynchronously; next frame_go starts at (0,0) buffer 0.
- frame_go during RUN -> ignored; tile count for the frame stays 8.
